// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU adder/logic hold stage.
// Consumed by alu_adder_hold and, in ALU_DECIMAL_EN builds, alu_bcd_adjust.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_SUM = 3'd0,
        OP_AND = 3'd1,
        OP_OR  = 3'd2,
        OP_EOR = 3'd3,
        OP_SR  = 3'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_ADJUST,
        ST_DONE
    } alu_state_t;

    localparam logic [3:0] BCD_ADJ       = 4'h6;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'h9;

endpackage

// File: rtl/alu_bcd_adjust.sv
// Combinational NMOS-style BCD correction of one binary adder byte.
// Only built when ALU_DECIMAL_EN is defined (the 2A03 build has no decimal mode).
`ifdef ALU_DECIMAL_EN
module alu_bcd_adjust
    import alu_pkg::*;
(
    input  logic [7:0] sum,
    input  logic       half,
    input  logic       carry,
    input  logic       subtract,
    output logic [7:0] adj,
    output logic       carry_adj
);

    logic [4:0] lo_raw;
    logic [4:0] lo_adj;
    logic       lo_gt9;
    logic [5:0] hi_raw;
    logic [5:0] hi_adj;

    always_comb begin
        // {half, sum[3:0]} is the full low-digit sum A_lo + B_lo + Cin.
        lo_raw = {half, sum[3:0]};
        lo_gt9 = (lo_raw > {1'b0, BCD_MAX_DIGIT});
        lo_adj = lo_gt9 ? (lo_raw + {1'b0, BCD_ADJ}) : lo_raw;
        // Binary high digit already carries 'half'; add the extra decimal carry only.
        hi_raw = {1'b0, carry, sum[7:4]} + {5'b0, (lo_gt9 && !half)};
        hi_adj = (hi_raw > {2'b0, BCD_MAX_DIGIT}) ? (hi_raw + {2'b0, BCD_ADJ}) : hi_raw;

        adj       = {hi_adj[3:0], lo_adj[3:0]};
        carry_adj = (hi_adj > 6'd15);

        if (subtract) begin
            adj[3:0]  = half  ? sum[3:0] : (sum[3:0] - BCD_ADJ);
            adj[7:4]  = carry ? sum[7:4] : (sum[7:4] - BCD_ADJ);
            carry_adj = carry;
        end
    end

endmodule
`endif

// File: rtl/alu_adder_hold.sv
// Registered 6502 adder/logic stage with adder hold register and start/done handshake.
// Define ALU_DECIMAL_EN to build the ADJUST state and BCD correction (DATA_W must be 8).
module alu_adder_hold
    import alu_pkg::*;
#(
    parameter int DATA_W = 8
)
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [DATA_W-1:0] AIn,
    input  logic [DATA_W-1:0] BIn,
    input  logic              CarryIn,
    input  logic              DecimalEn,
    input  logic              Subtract,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] AddHold,
    output logic              CarryOut,
    output logic              OverflowOut,
    output logic              HalfCarry
);

    alu_state_t        state, state_nx;
    logic              accept;
    logic              go_adjust;

    logic [DATA_W-1:0] a_p0, b_p0;
    logic              cin_p0;
    logic [2:0]        op_p0;

    logic [DATA_W:0]   sum9;
    logic [4:0]        sum_lo;
    logic [DATA_W-1:0] res_nx;
    logic              c_nx, v_nx, h_nx;

    assign accept = Start && ((state == ST_IDLE) || (state == ST_DONE));

`ifdef ALU_DECIMAL_EN
    logic       dec_p0, sub_p0;
    logic [7:0] adj_res;
    logic       adj_c;

    always_ff @(posedge Clk) begin
        if (accept) begin
            dec_p0 <= DecimalEn;
            sub_p0 <= Subtract;
        end
    end

    // Codes 5-7 behave as SUM, so anything that is not a logic/shift op adjusts.
    assign go_adjust = dec_p0 && !(op_p0 inside {OP_AND, OP_OR, OP_EOR, OP_SR});

    alu_bcd_adjust u_bcd (
        .sum       (AddHold),
        .half      (HalfCarry),
        .carry     (CarryOut),
        .subtract  (sub_p0),
        .adj       (adj_res),
        .carry_adj (adj_c)
    );
`else
    logic unused_dec;
    assign unused_dec = ^{DecimalEn, Subtract};
    assign go_adjust  = 1'b0;
`endif

    // p0: operand latch, deliberately not reset
    always_ff @(posedge Clk) begin
        if (accept) begin
            a_p0   <= AIn;
            b_p0   <= BIn;
            cin_p0 <= CarryIn;
            op_p0  <= Op;
        end
    end

    always_comb begin
        sum9   = {1'b0, a_p0} + {1'b0, b_p0} + {{DATA_W{1'b0}}, cin_p0};
        sum_lo = {1'b0, a_p0[3:0]} + {1'b0, b_p0[3:0]} + {4'b0, cin_p0};
        res_nx = sum9[DATA_W-1:0];
        c_nx   = sum9[DATA_W];
        v_nx   = (a_p0[DATA_W-1] == b_p0[DATA_W-1]) && (sum9[DATA_W-1] != a_p0[DATA_W-1]);
        h_nx   = sum_lo[4];
        case (op_p0)
            OP_AND: begin res_nx = a_p0 & b_p0; c_nx = 1'b0; v_nx = 1'b0; h_nx = 1'b0; end
            OP_OR:  begin res_nx = a_p0 | b_p0; c_nx = 1'b0; v_nx = 1'b0; h_nx = 1'b0; end
            OP_EOR: begin res_nx = a_p0 ^ b_p0; c_nx = 1'b0; v_nx = 1'b0; h_nx = 1'b0; end
            OP_SR:  begin
                res_nx = {cin_p0, a_p0[DATA_W-1:1]};
                c_nx   = a_p0[0];
                v_nx   = 1'b0;
                h_nx   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            ST_IDLE:    if (Start) state_nx = ST_COMPUTE;
            ST_COMPUTE: begin
                Busy     = 1'b1;
                state_nx = go_adjust ? ST_ADJUST : ST_DONE;
            end
            ST_ADJUST:  begin
                Busy     = 1'b1;
                state_nx = ST_DONE;
            end
            ST_DONE:    begin
                Done     = 1'b1;
                state_nx = Start ? ST_COMPUTE : ST_IDLE;
            end
            default:    state_nx = ST_IDLE;
        endcase
    end

    // p1: adder hold register, refined in place by ADJUST
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            AddHold     <= '0;
            CarryOut    <= 1'b0;
            OverflowOut <= 1'b0;
            HalfCarry   <= 1'b0;
        end else if (state == ST_COMPUTE) begin
            AddHold     <= res_nx;
            CarryOut    <= c_nx;
            OverflowOut <= v_nx;
            HalfCarry   <= h_nx;
        end
`ifdef ALU_DECIMAL_EN
        else if (state == ST_ADJUST) begin
            AddHold  <= adj_res;
            CarryOut <= adj_c;
        end
`endif
    end

endmodule

// File: doc/alu_adder_hold.md
# alu_adder_hold

Registered adder/logic stage of the 6502 ALU, directly downstream of the B-input inverter. It latches the A input and the already-conditioned B input plus carry, then computes SUM/AND/OR/EOR/SR. It applies optional BCD correction and holds the result and flags in the adder hold register for the internal bus. Operation uses a start/done handshake.

## Interface
- DATA_W, 8, datapath width. Only 8 is supported when decimal mode is compiled in.
- Clk  in  1  clock; all state changes on rising edge.
- Reset_n  in  1  reset; asynchronous, active-low.
- Start  in  1  operand-valid strobe. Accepted only in IDLE or DONE.
- Op  in  3  operation: SUM=0, AND=1, OR=2, EOR=3, SR=4. Codes 5–7 are treated as SUM.
- AIn  in  DATA_W  A operand.
- BIn  in  DATA_W  B operand. Already inverted upstream for SBC.
- CarryIn  in  1  carry/borrow-not in; SR shift-in bit.
- DecimalEn  in  1  processor D flag.
- Subtract  in  1  1 = SBC. Selects the direction of the decimal correction only.
- Busy  out  1  high in COMPUTE and ADJUST.
- Done  out  1  one-cycle pulse in the DONE state.
- AddHold  out  DATA_W  registered result.
- CarryOut, OverflowOut, HalfCarry  out  1 each  registered flags.

## Operation
- States: IDLE, COMPUTE, ADJUST, DONE.
- On an accepted Start:
  - Latch AIn, BIn, CarryIn, Op, DecimalEn, Subtract.
  - Go to COMPUTE.
  - Later input changes have no effect.
- COMPUTE:
  - SUM:
    - Sum9 = A + B + Cin.
    - HalfCarry = carry out of bit 3.
    - CarryOut = Sum9[8].
    - OverflowOut = (A[7]==B[7]) && (Sum9[7]!=A[7]).
  - AND/OR/EOR: bitwise result; CarryOut = 0, OverflowOut = 0, HalfCarry = 0.
  - SR: result = {Cin, A[7:1]}; CarryOut = A[0]; OverflowOut = 0, HalfCarry = 0.
  - Next state: ADJUST if Op is SUM and the latched DecimalEn is 1; otherwise DONE.
- ADJUST (decimal, NMOS semantics; V keeps its binary value):
  - ADC:
    - Low digit: AL = A[3:0] + B[3:0] + Cin. If AL > 9, AL += 6.
    - High digit: AH = A[7:4] + B[7:4] + (AL > 15). If AH > 9, AH += 6.
    - CarryOut = AH > 15. AddHold = {AH[3:0], AL[3:0]}.
  - SBC:
    - Start from the binary result.
    - If HalfCarry == 0, subtract 6 from the low digit.
    - If the binary CarryOut == 0, subtract 0x60.
    - CarryOut keeps its binary value.
  - Next state: DONE.
- DONE:
  - Done = 1 for this cycle.
  - If Start is high: accept it and go to COMPUTE.
  - Otherwise: go to IDLE.
- AddHold and the flags stay stable from DONE until the next COMPUTE/ADJUST update.
- Start while Busy is ignored and not queued.

## Timing
- Reset values: state IDLE; AddHold = 0; CarryOut = OverflowOut = HalfCarry = 0; Busy = 0; Done = 0.
- Reset is asynchronous. Asserting it in any state, including mid-ADJUST, forces the reset values immediately and discards the operation.
- Latency, counted from the Start edge to the Done-high cycle:
  - Binary ops and logic ops: 2 cycles.
  - Decimal SUM: 3 cycles.
- AddHold and the flags are valid in the Done cycle and afterwards.
- Back-to-back throughput: one binary op per 2 cycles, because Start in DONE is accepted.

## Configuration
- ALU_DECIMAL_EN defined: ADJUST state and BCD correction are present, as above.
- ALU_DECIMAL_EN undefined (2A03 build):
  - DecimalEn is ignored and the ADJUST state is not synthesized.
  - All SUM ops are binary with 2-cycle latency.

## Structure
- Shared package alu_pkg holds:
  - alu_op_t enum (SUM, AND, OR, EOR, SR).
  - alu_state_t enum.
  - BCD_ADJ = 4'h6 and BCD_MAX_DIGIT = 4'h9.
- One sub-module, alu_bcd_adjust:
  - Combinational per-byte correction.
  - Inputs: binary sum, HalfCarry, carry, Subtract. Outputs: adjusted byte, carry.
  - Instantiated only under ALU_DECIMAL_EN.

## Test plan
- Binary ADC 0x50+0x50, Cin=0, D=0 -> AddHold=0xA0, C=0, V=1, H=0; Done pulses 2 cycles after Start.
- Binary SBC 0x50−0x01 (BIn=0xFE, Cin=1, Subtract=1) -> 0x4F, C=1, V=0, H=0.
- Decimal ADC 0x19+0x28, Cin=0 -> 0x47, C=0.
- Decimal ADC 0x99+0x01, Cin=0 -> 0x00, C=1.
- Decimal SBC 0x50−0x01 (BIn=0xFE, Cin=1, Subtract=1) -> 0x49, C=1; Done at 3 cycles.
- Without ALU_DECIMAL_EN, the same stimulus gives binary results at 2 cycles.
- SR with A=0x81, Cin=1 -> 0xC0, C=1.
- Start held high while Busy: ignored; a new operation is accepted on the Done cycle and Done pulses 2 cycles later.
- Reset_n pulsed low in ADJUST -> outputs 0 at once; state IDLE; no Done pulse.
